// File: rtl/wb_pkg.sv
// Shared types and default constants for the writeback select unit.
package wb_pkg;

    // Controller states: idle accepting requests, or waiting on a memory load.
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    // Load extension codes carried on ld_mode.
    localparam logic [1:0] LD_WORD   = 2'b00;
    localparam logic [1:0] LD_BYTE_S = 2'b01;
    localparam logic [1:0] LD_BYTE_U = 2'b10;
    localparam logic [1:0] LD_HALF_S = 2'b11;

    // Default parameterisation.
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NSRC    = 4;
    localparam int DEF_MEM_IDX = 1;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw load data according to the load mode.
module load_extend
    import wb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       ld_mode,
    output logic [WIDTH-1:0] ext
);

    // Select the extended value; word mode passes the data through untouched.
    always_comb begin
        ext = data;
        case (ld_mode)
            LD_BYTE_S: ext = {{(WIDTH-8){data[7]}}, data[7:0]};
            LD_BYTE_U: ext = {{(WIDTH-8){1'b0}}, data[7:0]};
            LD_HALF_S: ext = {{(WIDTH-16){data[15]}}, data[15:0]};
            default:   ext = data;
        endcase
    end

endmodule

// File: rtl/wb_select_unit.sv
// Writeback source selector with a memory-load wait state and a one-entry
// output slot. Non-memory sources produce a result one cycle after accept;
// memory loads wait for mem_rvalid or a bounded timeout.
module wb_select_unit
    import wb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NSRC    = DEF_NSRC,
    parameter int MEM_IDX = DEF_MEM_IDX,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NSRC*WIDTH-1:0]     src_data,
    input  logic [$clog2(NSRC)-1:0]   sel,
    input  logic [1:0]                ld_mode,
    input  logic [4:0]                rd,
    input  logic [WIDTH-1:0]          mem_rdata,
    input  logic                      mem_rvalid,
    output logic                      mem_rready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [4:0]                out_rd,
    output logic                      out_we,
    output logic                      out_err
);

    localparam int SELW = $clog2(NSRC);
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam logic [SELW:0]   NSRC_W   = (SELW+1)'(NSRC);
    localparam logic [SELW-1:0] MEM_SEL  = SELW'(MEM_IDX);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    wb_state_e        state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [4:0]       rd_lat_reg, rd_lat_next;
    logic [1:0]       mode_lat_reg, mode_lat_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [4:0]       out_rd_reg, out_rd_next;
    logic             out_we_reg, out_we_next;
    logic             out_err_reg, out_err_next;

    logic [WIDTH-1:0] src_slice [NSRC];
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] ext_data;
    logic             sel_in_range;
    logic             slot_free;

    // Split the flat source bus into per-source words.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign src_slice[gi] = src_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Source mux; out-of-range selects read as zero.
    always_comb begin
        sel_in_range = ({1'b0, sel} < NSRC_W);
        sel_data     = '0;
        if (sel_in_range) begin
            sel_data = src_slice[sel];
        end
    end

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .data    (mem_rdata),
        .ld_mode (mode_lat_reg),
        .ext     (ext_data)
    );

    // State, counter, latched load context and output slot registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            rd_lat_reg    <= '0;
            mode_lat_reg  <= LD_WORD;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_rd_reg    <= '0;
            out_we_reg    <= 1'b0;
            out_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rd_lat_reg    <= rd_lat_next;
            mode_lat_reg  <= mode_lat_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_rd_reg    <= out_rd_next;
            out_we_reg    <= out_we_next;
            out_err_reg   <= out_err_next;
        end
    end

    // Next-state logic, handshakes and output-slot loading.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rd_lat_next    = rd_lat_reg;
        mode_lat_next  = mode_lat_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_rd_next    = out_rd_reg;
        out_we_next    = out_we_reg;
        out_err_next   = out_err_reg;

        slot_free  = !out_valid_reg || out_ready;
        in_ready   = (state_reg == ST_IDLE) && slot_free;
        mem_rready = (state_reg == ST_WAIT_MEM) && slot_free;

        // A consumed result empties the slot unless something reloads it below.
        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (sel == MEM_SEL) begin
                        state_next    = ST_WAIT_MEM;
                        cnt_next      = '0;
                        rd_lat_next   = rd;
                        mode_lat_next = ld_mode;
                    end else begin
                        out_valid_next = 1'b1;
                        out_data_next  = sel_data;
                        out_rd_next    = rd;
                        out_we_next    = sel_in_range && (rd != 5'd0);
                        out_err_next   = 1'b0;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid && mem_rready) begin
                    state_next     = ST_IDLE;
                    out_valid_next = 1'b1;
                    out_data_next  = ext_data;
                    out_rd_next    = rd_lat_reg;
                    out_we_next    = (rd_lat_reg != 5'd0);
                    out_err_next   = 1'b0;
                end else if (cnt_reg == CNT_LAST) begin
                    // Counter holds here until the slot frees for the error result.
                    if (slot_free) begin
                        state_next     = ST_IDLE;
                        out_valid_next = 1'b1;
                        out_data_next  = '0;
                        out_rd_next    = rd_lat_reg;
                        out_we_next    = 1'b0;
                        out_err_next   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_rd    = out_rd_reg;
    assign out_we    = out_we_reg;
    assign out_err   = out_err_reg;

endmodule
